// File: rtl/seg_display_reader.sv
// seg_display_reader
//   Snoops a time-multiplexed, active-low 7-segment display bus and recovers
//   the hexadecimal value shown on each of four digits.
//
//   The block samples {DigitEn, Seg} on every edge. A pattern is accepted
//   only after STABLE_CYCLES consecutive identical samples. A stable run
//   produces exactly one capture, so the bus can be held without re-capturing.
//
// Parameters
//   STABLE_CYCLES : consecutive identical samples required (2..255)
// Ports
//   Clock    in   system clock, rising edge
//   Reset    in   synchronous, active-high
//   DigitEn  in   [3:0] one-hot digit select, bit i = digit i
//   Seg      in   [0:6] segments a..g, active-low, Seg[0] = a
//   Value    out  [15:0] recovered digits, digit i in Value[4i+3:4i]
//   Valid    out  all four digits captured since reset
//   Update   out  one-cycle pulse on a new or changed digit capture
//   Error    out  sticky, set on an unrecognised lit pattern
//   ErrDigit out  [1:0] digit that most recently raised Error
module seg_display_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [3:0]  DigitEn,
    input  logic [0:6]  Seg,
    output logic [15:0] Value,
    output logic        Valid,
    output logic        Update,
    output logic        Error,
    output logic [1:0]  ErrDigit
);

    localparam logic [7:0] SAT_COUNT = 8'(STABLE_CYCLES);
    localparam logic [7:0] CAP_COUNT = 8'(STABLE_CYCLES - 1);

    logic [10:0] sample_q,    sample_d;
    logic [7:0]  count_q,     count_d;
    logic [15:0] value_q,     value_d;
    logic [3:0]  seen_q,      seen_d;
    logic        valid_q,     valid_d;
    logic        update_q,    update_d;
    logic        error_q,     error_d;
    logic [1:0]  err_digit_q, err_digit_d;

    logic [10:0] sample_in;
    logic        stable;
    logic        capture;
    logic        en_onehot;
    logic        seg_blank;
    logic        seg_hit;
    logic [3:0]  seg_nibble;
    logic [1:0]  digit_idx;
    logic [3:0]  old_nibble;

    assign sample_in = {DigitEn, Seg};
    assign stable    = (sample_in == sample_q);
    // Count saturates at STABLE_CYCLES, so only one edge per run can match.
    assign capture   = stable && (count_q == CAP_COUNT);
    assign en_onehot = (DigitEn != '0) && ((DigitEn & (DigitEn - 4'd1)) == '0);
    assign seg_blank = (Seg == '1);

    // Inverse of the nibble-to-segment decoder (abcdefg, active-low).
    always_comb begin
        seg_hit    = 1'b1;
        seg_nibble = '0;
        case (Seg)
            7'b0000001: seg_nibble = 4'h0;
            7'b1001111: seg_nibble = 4'h1;
            7'b0010010: seg_nibble = 4'h2;
            7'b0000110: seg_nibble = 4'h3;
            7'b1001100: seg_nibble = 4'h4;
            7'b0100100: seg_nibble = 4'h5;
            7'b0100000: seg_nibble = 4'h6;
            7'b0001111: seg_nibble = 4'h7;
            7'b0000000: seg_nibble = 4'h8;
            7'b0000100: seg_nibble = 4'h9;
            7'b0001000: seg_nibble = 4'hA;
            7'b1100000: seg_nibble = 4'hB;
            7'b0110001: seg_nibble = 4'hC;
            7'b1000010: seg_nibble = 4'hD;
            7'b0110000: seg_nibble = 4'hE;
            7'b0111000: seg_nibble = 4'hF;
            default:    seg_hit    = 1'b0;
        endcase
    end

    // Index is only meaningful when DigitEn is one-hot.
    always_comb begin
        digit_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (DigitEn[i]) begin
                digit_idx = 2'(i);
            end
        end
    end

    assign old_nibble = value_q[{digit_idx, 2'b00} +: 4];

    always_comb begin
        sample_d    = sample_in;
        value_d     = value_q;
        seen_d      = seen_q;
        update_d    = 1'b0;
        error_d     = error_q;
        err_digit_d = err_digit_q;

        if (!stable) begin
            count_d = 8'd1;
        end else if (count_q < SAT_COUNT) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = SAT_COUNT;
        end

        if (capture && en_onehot && !seg_blank) begin
            if (seg_hit) begin
                value_d[{digit_idx, 2'b00} +: 4] = seg_nibble;
                seen_d[digit_idx]                = 1'b1;
                update_d = (old_nibble != seg_nibble) || !seen_q[digit_idx];
            end else begin
                error_d     = 1'b1;
                err_digit_d = digit_idx;
            end
        end

        valid_d = &seen_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sample_q    <= '0;
            count_q     <= '0;
            value_q     <= '0;
            seen_q      <= '0;
            valid_q     <= 1'b0;
            update_q    <= 1'b0;
            error_q     <= 1'b0;
            err_digit_q <= '0;
        end else begin
            sample_q    <= sample_d;
            count_q     <= count_d;
            value_q     <= value_d;
            seen_q      <= seen_d;
            valid_q     <= valid_d;
            update_q    <= update_d;
            error_q     <= error_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign Value    = value_q;
    assign Valid    = valid_q;
    assign Update   = update_q;
    assign Error    = error_q;
    assign ErrDigit = err_digit_q;

endmodule

// File: tb/tb_seg_display_reader.sv
// tb_seg_display_reader
//   Directed bench for seg_display_reader. A behavioural model of the
//   digit/seen/error state is advanced per stimulus run; each expected
//   Update pulse (cycle and Value) is queued and matched when the DUT
//   pulses Update.
module tb_seg_display_reader;

    localparam int unsigned STABLE = 4;

    logic        Clock;
    logic        Reset;
    logic [3:0]  DigitEn;
    logic [0:6]  Seg;
    logic [15:0] Value;
    logic        Valid;
    logic        Update;
    logic        Error;
    logic [1:0]  ErrDigit;

    seg_display_reader #(.STABLE_CYCLES(STABLE)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .DigitEn  (DigitEn),
        .Seg      (Seg),
        .Value    (Value),
        .Valid    (Valid),
        .Update   (Update),
        .Error    (Error),
        .ErrDigit (ErrDigit)
    );

    typedef struct {
        int unsigned cyc;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        popped;
    int unsigned cyc;
    int unsigned nasserts;
    int unsigned nfail;

    logic [15:0] m_val;
    logic [3:0]  m_seen;
    logic        m_err;
    logic [1:0]  m_errd;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [6:0] pat(input int unsigned d);
        case (d)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasserts++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_value"},    32'(Value),    32'(m_val));
        chk({tag, "_valid"},    32'(Valid),    32'(&m_seen));
        chk({tag, "_error"},    32'(Error),    32'(m_err));
        chk({tag, "_errdigit"}, 32'(ErrDigit), 32'(m_errd));
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Presents a new {en, sg} (must differ from the previous input) for n edges.
    task automatic hold(input logic [3:0] en, input logic [6:0] sg, input int unsigned n);
        int unsigned start;
        int          idx;
        int          nib;
        logic [15:0] nv;
        DigitEn = en;
        Seg     = sg;
        start   = cyc;
        if (n >= STABLE && $countones(en) == 1 && sg != 7'b1111111) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (en[i]) idx = i;
            nib = -1;
            for (int d = 0; d < 16; d++) if (pat(d) == sg) nib = d;
            if (nib >= 0) begin
                nv = m_val;
                nv[idx*4 +: 4] = 4'(nib);
                if (!m_seen[idx] || m_val[idx*4 +: 4] != 4'(nib))
                    sb.push_back('{start + STABLE, nv});
                m_val       = nv;
                m_seen[idx] = 1'b1;
            end else begin
                m_err  = 1'b1;
                m_errd = 2'(idx);
            end
        end
        tick(n);
    endtask

    task automatic model_reset();
        m_val  = '0;
        m_seen = '0;
        m_err  = 1'b0;
        m_errd = '0;
    endtask

    always @(negedge Clock) begin
        if (Update === 1'b1) begin
            nasserts++;
            assert (sb.size() > 0) else begin
                nfail++;
                $error("FAIL update_unexpected: observed pulse at cycle %0d, expected none", cyc);
            end
            if (sb.size() > 0) begin
                popped = sb.pop_front();
                chk("update_cycle", cyc, popped.cyc);
                chk("update_value", 32'(Value), 32'(popped.val));
            end
        end
    end

    initial begin
        nasserts = 0;
        nfail    = 0;
        model_reset();

        // Reset with garbage on the bus.
        Reset   = 1'b1;
        DigitEn = 4'b1111;
        Seg     = 7'b0101010;
        tick(2);
        Reset = 1'b0;
        chk("reset_update", 32'(Update), 32'd0);
        check_state("reset");

        // Reset during the third stable cycle of a run: nothing captured.
        DigitEn = 4'b0001;
        Seg     = pat(8);
        tick(2);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        model_reset();
        hold(4'b0000, pat(0), 6);
        check_state("midreset");

        // Single capture, then an extended hold that must not re-capture.
        hold(4'b0001, pat(5), 4);
        check_state("single");
        tick(10);
        check_state("single_hold");

        // Glitch rejection: 8 shown for only three edges.
        hold(4'b0010, pat(8), 3);
        hold(4'b0010, pat(9), 4);
        check_state("glitch");

        // Full scan A,3,F,1 then a rescan with identical values.
        hold(4'b0001, pat(10), 4);
        hold(4'b0010, pat(3),  4);
        hold(4'b0100, pat(15), 4);
        chk("scan_valid_pre", 32'(Valid), 32'd0);
        hold(4'b1000, pat(1),  4);
        check_state("scan");
        chk("scan_value_const", 32'(Value), 32'h1F3A);
        hold(4'b0001, pat(10), 4);
        hold(4'b0010, pat(3),  4);
        hold(4'b0100, pat(15), 4);
        hold(4'b1000, pat(1),  4);
        check_state("rescan");

        // Unrecognised pattern, then a valid capture that keeps Error set.
        hold(4'b0100, 7'b1111110, 4);
        check_state("bad");
        hold(4'b0100, pat(14), 4);
        check_state("bad_then_good");
        hold(4'b0010, 7'b1111100, 4);
        check_state("bad_digit1");

        // Illegal selects and blank pattern.
        hold(4'b0011, pat(0), 6);
        hold(4'b0000, pat(0), 6);
        hold(4'b1000, 7'b1111111, 6);
        check_state("illegal");

        // One edge short of capture, then re-present the stored value.
        hold(4'b1000, pat(8), STABLE - 1);
        hold(4'b1000, pat(1), 4);
        check_state("represent");

        tick(5);
        chk("pending_updates", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
        $finish;
    end

endmodule

// File: doc/seg_display_reader.md
# seg_display_reader

Recovers hexadecimal digit values from a time-multiplexed, active-low 7-segment display bus; it is the inverse of the team's nibble-to-segment decoder. It sits on the display side of the board as a self-check/snoop block: it samples digit enables and segment lines, qualifies each pattern by stability, and maps it back to a 4-bit value per digit. Results feed the test harness and the on-chip status registers.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required to accept a pattern; legal range 2..255.
- Clock  input  1  system clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-high; one clock, synchronous reset, active-high.
- DigitEn  input  4  digit select, active-high; bit i selects display digit i; legal when one-hot.
- Seg  input  [0:6]  segment lines a..g, active-low (0 = lit); Seg[0] = a, Seg[6] = g.
- Value  output  16  recovered digits; digit i in Value[4i+3:4i].
- Valid  output  1  high once all four digits have been captured since reset.
- Update  output  1  one-cycle pulse when a capture changes a digit or captures it for the first time.
- Error  output  1  sticky; set on an unrecognised lit pattern.
- ErrDigit  output  2  index of the digit that most recently caused Error.

## Operation
- Pattern table (abcdefg, active-low), identical to the team decoder: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Sample register S holds the previous {DigitEn, Seg}. Count tracks the number of consecutive edges on which the current input has been sampled.
  - Input equals S: Count <= min(Count+1, STABLE_CYCLES).
  - Otherwise: Count <= 1.
  - S <= input on every edge.
- A capture event occurs on the edge where the input equals S and Count == STABLE_CYCLES-1, so Count reaches STABLE_CYCLES. Saturation guarantees exactly one event per stable run.
- At a capture event:
  - DigitEn not one-hot (zero or multiple bits): no action.
  - One-hot i, Seg = 1111111 (blank): no action, no error.
  - One-hot i, Seg in table: Value digit i <= nibble, seen[i] <= 1. Update pulses if the nibble differs from the stored value or seen[i] was 0.
  - One-hot i, Seg not in table and not blank: Error <= 1, ErrDigit <= i. Value and seen are unchanged.
- Valid = AND of seen[3:0]. Valid never falls except on Reset.
- Error is cleared only by Reset. A later bad pattern overwrites ErrDigit.

## Timing
- Reset values: Value = 0, Valid = 0, Update = 0, Error = 0, ErrDigit = 0, seen = 0, S = 0, Count = 0.
- Reset mid-run: all state returns to reset values at that edge. Stability counting restarts on the first edge after Reset deasserts.
- Latency: the new input is first sampled at edge E0. Value, Update, Error and ErrDigit change at edge E(STABLE_CYCLES-1) and are visible in the following cycle. For the default, that is the 4th edge.
- Update is high for exactly one cycle per qualifying capture. Consecutive captures on back-to-back stable runs are impossible closer than STABLE_CYCLES cycles apart.
- A change of DigitEn or of any Seg bit before the capture edge resets Count to 1; nothing is captured (glitch rejection).
- Holding a pattern indefinitely produces one capture only. Re-presenting the same value after a different input produces a new capture with no Update pulse.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
- Reset: drive garbage on the bus, assert Reset for 1 cycle -> all outputs 0. Assert Reset during the 3rd stable cycle of a run -> no capture, outputs 0.
- Single capture: DigitEn=0001, Seg=0100100 held 4 edges -> Value=16'h0005 after the 4th edge, Update high 1 cycle, Valid=0. Hold 10 more cycles -> no further Update.
- Glitch rejection: DigitEn=0010, Seg=0000000 for 3 edges, then Seg=0000100 for 4 edges -> Value[7:4]=9 only, one Update pulse, 8 never captured.
- Full scan: digits 0..3 present A, 3, F, 1 (4 cycles each) -> Value=16'h1F3A. Valid rises with the digit-3 capture. Rescan the same values -> no Update pulses.
- Bad pattern: DigitEn=0100, Seg=1111110 for 4 edges -> Error=1, ErrDigit=2, Value unchanged. A following valid capture leaves Error=1.
- Illegal select/blank: DigitEn=0011 or 0000 with Seg=0000001, and DigitEn=1000 with Seg=1111111, each for 6 edges -> no Value change, no Update, no Error.
